// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   ALU_*       5-bit operation codes presented on alu_op_i
//   MEM_*       4-bit memory operation codes driven on ram_op_o
//   div_state_e state encoding of the iterative divider
package ex_pkg;

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_NOR  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_SLT  = 5'd10;
    localparam logic [4:0] ALU_MOV  = 5'd11;
    localparam logic [4:0] ALU_BAJ  = 5'd12;
    localparam logic [4:0] ALU_MULT = 5'd13;
    localparam logic [4:0] ALU_DIV  = 5'd14;
    localparam logic [4:0] ALU_LB   = 5'd15;
    localparam logic [4:0] ALU_LBU  = 5'd16;
    localparam logic [4:0] ALU_LH   = 5'd17;
    localparam logic [4:0] ALU_LHU  = 5'd18;
    localparam logic [4:0] ALU_LW   = 5'd19;
    localparam logic [4:0] ALU_SB   = 5'd20;
    localparam logic [4:0] ALU_SH   = 5'd21;
    localparam logic [4:0] ALU_SW   = 5'd22;

    localparam logic [3:0] MEM_NOP  = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LBU  = 4'd2;
    localparam logic [3:0] MEM_LH   = 4'd3;
    localparam logic [3:0] MEM_LHU  = 4'd4;
    localparam logic [3:0] MEM_LW   = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div_iter.sv
// ex_div_iter: iterative restoring divider, one quotient bit per clock.
//   clk, rst_n    clock, asynchronous active-low reset
//   i_start       begin a divide (sampled in IDLE)
//   i_signed      treat operands as two's complement
//   i_abort       return to IDLE immediately (wins over start)
//   i_ack         result consumed; leave DONE
//   i_dividend    dividend
//   i_divisor     divisor
//   o_busy        iteration in progress
//   o_done        result valid
//   o_quotient    sign-corrected quotient
//   o_remainder   sign-corrected remainder (sign of dividend)
// Divisor zero skips iteration: quotient all-ones, remainder = dividend.
module ex_div_iter
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic              i_abort,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    div_state_e        r_state;
    div_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic              w_div_zero;
    logic              w_accept;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_trial;

    always_comb begin
        w_a_neg    = i_signed & i_dividend[DATA_W-1];
        w_b_neg    = i_signed & i_divisor[DATA_W-1];
        w_a_mag    = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
        w_b_mag    = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
        w_div_zero = (i_divisor == '0);
        w_accept   = (r_state == DIV_IDLE) & i_start & ~i_abort;
        // Partial remainder shifted left with the next dividend bit; a set
        // MSB after subtraction means the trial borrowed (restore).
        w_shift    = {r_rem, r_q[DATA_W-1]};
        w_trial    = w_shift - {1'b0, r_dvs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= DIV_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (w_accept) w_state_nxt = w_div_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (r_cnt == '0) w_state_nxt = DIV_DONE;
            DIV_DONE: if (i_ack) w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (i_abort) w_state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(DATA_W - 1);
            r_dvs <= w_b_mag;
            if (w_div_zero) begin
                r_q     <= '1;
                r_rem   <= i_dividend;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_q     <= w_a_mag;
                r_rem   <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
        end else if (r_state == DIV_BUSY) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (!w_trial[DATA_W]) begin
                r_rem <= w_trial[DATA_W-1:0];
                r_q   <= {r_q[DATA_W-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_W-1:0];
                r_q   <= {r_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign o_busy      = (r_state == DIV_BUSY);
    assign o_done      = (r_state == DIV_DONE);
    assign o_quotient  = r_neg_q ? (~r_q + 1'b1) : r_q;
    assign o_remainder = r_neg_r ? (~r_rem + 1'b1) : r_rem;

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage registered into the EX/MEM boundary.
//   clk, rst_n       clock, asynchronous active-low reset
//   valid_i          live instruction in ID/EX
//   flush_i          kill the instruction in EX and abort any divide
//   mem_stall_i      hold the EX/MEM register (divider keeps running)
//   alu_op_i         operation (ex_pkg ALU_*)
//   oprand1_i/2_i    operands; base address / store data / shift amount
//   imm_i            load/store offset, sign-extended
//   signed_i         signed SLT/MULT/DIV (and ADD/SUB overflow trap)
//   write_*_i        destination register / GPR write / HI-LO write
//   pc_i             instruction PC
//   *_o              registered EX/MEM outputs; ram_op_o per ex_pkg MEM_*
//   pause_request_o  combinational stall request while a divide runs
// Build option: define EX_OVERFLOW_TRAP_EN to add ovf_exc_o and suppress
// the GPR write of signed ADD/SUB that overflow.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              mem_stall_i,
    input  logic [4:0]        alu_op_i,
    input  logic [DATA_W-1:0] oprand1_i,
    input  logic [DATA_W-1:0] oprand2_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic              write_enable_i,
    input  logic [1:0]        write_hilo_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] write_addr_o,
    output logic              write_enable_o,
    output logic [1:0]        write_hilo_o,
    output logic [DATA_W-1:0] hi_data_o,
    output logic [DATA_W-1:0] lo_data_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [3:0]        ram_op_o,
    output logic [DATA_W-1:0] pc_o,
    output logic              pause_request_o
`ifdef EX_OVERFLOW_TRAP_EN
    ,
    output logic              ovf_exc_o
`endif
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [ADDR_W-1:0] r_waddr;
    logic              r_valid;
    logic              r_we;
    logic [1:0]        r_hilo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_store;
    logic [3:0]        r_ram_op;
    logic [DATA_W-1:0] r_pc;

    logic [DATA_W-1:0]   w_hi;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_store;
    logic [3:0]          w_ram_op;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_imm_ext;
    logic [SH_W-1:0]     w_sh;
    logic                w_lt;
    logic [2*DATA_W-1:0] w_mul_a;
    logic [2*DATA_W-1:0] w_mul_b;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_we_kill;
    logic                w_adv;

    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [DATA_W-1:0] w_div_quo;
    logic [DATA_W-1:0] w_div_rem;

    // Start only from IDLE; a held DIV in DONE must not relaunch.
    assign w_div_start = valid_i & (alu_op_i == ALU_DIV) & ~flush_i
                       & ~w_div_busy & ~w_div_done;
    assign pause_request_o = rst_n & (w_div_start | w_div_busy);
    assign w_adv = ~mem_stall_i & ~pause_request_o;

    ex_div_iter #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_div_start),
        .i_signed    (signed_i),
        .i_abort     (flush_i),
        .i_ack       (~mem_stall_i),
        .i_dividend  (oprand1_i),
        .i_divisor   (oprand2_i),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    always_comb begin
        w_imm_ext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
        w_sum     = oprand1_i + oprand2_i;
        w_diff    = oprand1_i - oprand2_i;
        w_addr    = oprand1_i + w_imm_ext;
        w_sh      = oprand2_i[SH_W-1:0];
        w_lt      = signed_i ? ($signed(oprand1_i) < $signed(oprand2_i))
                             : (oprand1_i < oprand2_i);
        // Operands widened (sign- or zero-) to the product width so one
        // unsigned multiply yields the correct low 2*DATA_W bits either way.
        w_mul_a   = signed_i ? {{DATA_W{oprand1_i[DATA_W-1]}}, oprand1_i}
                             : {{DATA_W{1'b0}}, oprand1_i};
        w_mul_b   = signed_i ? {{DATA_W{oprand2_i[DATA_W-1]}}, oprand2_i}
                             : {{DATA_W{1'b0}}, oprand2_i};
        w_prod    = w_mul_a * w_mul_b;
    end

    always_comb begin
        w_hi     = '0;
        w_lo     = '0;
        w_store  = '0;
        w_ram_op = MEM_NOP;
        case (alu_op_i)
            ALU_ADD:  w_lo = w_sum;
            ALU_SUB:  w_lo = w_diff;
            ALU_AND:  w_lo = oprand1_i & oprand2_i;
            ALU_OR:   w_lo = oprand1_i | oprand2_i;
            ALU_XOR:  w_lo = oprand1_i ^ oprand2_i;
            ALU_NOR:  w_lo = ~(oprand1_i | oprand2_i);
            ALU_SLL:  w_lo = oprand1_i << w_sh;
            ALU_SRL:  w_lo = oprand1_i >> w_sh;
            ALU_SRA:  w_lo = $signed(oprand1_i) >>> w_sh;
            ALU_SLT:  w_lo = {{(DATA_W-1){1'b0}}, w_lt};
            ALU_MOV: begin
                if (write_hilo_i == 2'b10) w_hi = oprand1_i;
                else                       w_lo = oprand1_i;
            end
            ALU_BAJ:  w_lo = oprand2_i;
            ALU_MULT: begin
                w_hi = w_prod[2*DATA_W-1:DATA_W];
                w_lo = w_prod[DATA_W-1:0];
            end
            ALU_DIV: begin
                w_hi = w_div_rem;
                w_lo = w_div_quo;
            end
            ALU_LB:  begin w_lo = w_addr; w_ram_op = MEM_LB;  end
            ALU_LBU: begin w_lo = w_addr; w_ram_op = MEM_LBU; end
            ALU_LH:  begin w_lo = w_addr; w_ram_op = MEM_LH;  end
            ALU_LHU: begin w_lo = w_addr; w_ram_op = MEM_LHU; end
            ALU_LW:  begin w_lo = w_addr; w_ram_op = MEM_LW;  end
            ALU_SB:  begin w_lo = w_addr; w_store = oprand2_i; w_ram_op = MEM_SB; end
            ALU_SH:  begin w_lo = w_addr; w_store = oprand2_i; w_ram_op = MEM_SH; end
            ALU_SW:  begin w_lo = w_addr; w_store = oprand2_i; w_ram_op = MEM_SW; end
            default: ;
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic w_ovf;
    logic r_ovf;

    always_comb begin
        w_ovf = 1'b0;
        case (alu_op_i)
            ALU_ADD: w_ovf = signed_i & (oprand1_i[DATA_W-1] == oprand2_i[DATA_W-1])
                                      & (w_sum[DATA_W-1] != oprand1_i[DATA_W-1]);
            ALU_SUB: w_ovf = signed_i & (oprand1_i[DATA_W-1] != oprand2_i[DATA_W-1])
                                      & (w_diff[DATA_W-1] != oprand1_i[DATA_W-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    assign w_we_kill = w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_ovf <= 1'b0;
        else if (flush_i) r_ovf <= 1'b0;
        else if (w_adv)   r_ovf <= valid_i & w_ovf;
    end

    assign ovf_exc_o = r_ovf;
`else
    assign w_we_kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_waddr  <= '0;
            r_we     <= 1'b0;
            r_hilo   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_store  <= '0;
            r_ram_op <= MEM_NOP;
            r_pc     <= '0;
        end else if (flush_i) begin
            r_valid  <= 1'b0;
            r_we     <= 1'b0;
            r_hilo   <= '0;
            r_ram_op <= MEM_NOP;
        end else if (w_adv) begin
            r_valid  <= valid_i;
            r_waddr  <= write_addr_i;
            r_we     <= valid_i & write_enable_i & ~w_we_kill;
            r_hilo   <= valid_i ? write_hilo_i : 2'b00;
            r_hi     <= w_hi;
            r_lo     <= w_lo;
            r_store  <= w_store;
            r_ram_op <= valid_i ? w_ram_op : MEM_NOP;
            r_pc     <= pc_i;
        end
    end

    assign valid_o        = r_valid;
    assign write_addr_o   = r_waddr;
    assign write_enable_o = r_we;
    assign write_hilo_o   = r_hilo;
    assign hi_data_o      = r_hi;
    assign lo_data_o      = r_lo;
    assign store_data_o   = r_store;
    assign ram_op_o       = r_ram_op;
    assign pc_o           = r_pc;

endmodule
